// File: rtl/clock_set_ctrl.sv
// Mode/set controller for the seconds/minutes/hours counters sharing one databus.
// RUN scans the bus for the display; SET captures, edits and force-loads one field.
module clock_set_ctrl #(
  parameter int W       = 6,
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59,
  parameter int HR_MAX  = 23,
  parameter int TIMEOUT = 10
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         btn_mode,
  input  logic         btn_inc,
  input  logic         btn_dec,
  input  logic [W-1:0] databus,
  output logic         sec_en,
  output logic         min_en,
  output logic         hr_en,
  output logic         sec_load,
  output logic         min_load,
  output logic         hr_load,
  output logic [W-1:0] load_data,
  output logic [1:0]   bus_sel,
  output logic         set_active,
  output logic [W-1:0] edit_val
);

  localparam int IW = $clog2(TIMEOUT);
  localparam logic [W-1:0]  LP_SEC_MAX   = W'(SEC_MAX);
  localparam logic [W-1:0]  LP_MIN_MAX   = W'(MIN_MAX);
  localparam logic [W-1:0]  LP_HR_MAX    = W'(HR_MAX);
  localparam logic [IW-1:0] LP_IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [1:0]    FLD_SEC      = 2'd0;
  localparam logic [1:0]    FLD_MIN      = 2'd1;
  localparam logic [1:0]    FLD_HR       = 2'd2;

  typedef enum logic [2:0] {
    RUN,
    CAP_HR,
    EDIT_HR,
    CAP_MIN,
    EDIT_MIN,
    CAP_SEC,
    EDIT_SEC
  } state_t;

  state_t        r_state, w_state_next;
  logic [1:0]    r_scan, w_scan_next;
  logic [W-1:0]  r_shadow, w_shadow_next;
  logic [IW-1:0] r_idle, w_idle_next;

  logic [1:0]   w_field;
  logic [W-1:0] w_max;
  logic         w_is_cap;
  logic         w_is_edit;
  logic         w_any_btn;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state  <= RUN;
      r_scan   <= 2'd0;
      r_shadow <= '0;
      r_idle   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_scan   <= w_scan_next;
      r_shadow <= w_shadow_next;
      r_idle   <= w_idle_next;
    end
  end

  // The field being addressed: the scan pointer in RUN, otherwise the field under edit.
  always_comb begin
    w_field   = r_scan;
    w_is_cap  = 1'b0;
    w_is_edit = 1'b0;
    case (r_state)
      CAP_HR:   begin w_field = FLD_HR;  w_is_cap  = 1'b1; end
      EDIT_HR:  begin w_field = FLD_HR;  w_is_edit = 1'b1; end
      CAP_MIN:  begin w_field = FLD_MIN; w_is_cap  = 1'b1; end
      EDIT_MIN: begin w_field = FLD_MIN; w_is_edit = 1'b1; end
      CAP_SEC:  begin w_field = FLD_SEC; w_is_cap  = 1'b1; end
      EDIT_SEC: begin w_field = FLD_SEC; w_is_edit = 1'b1; end
      default:  begin w_field = r_scan; end
    endcase
  end

  always_comb begin
    case (w_field)
      FLD_HR:  w_max = LP_HR_MAX;
      FLD_MIN: w_max = LP_MIN_MAX;
      default: w_max = LP_SEC_MAX;
    endcase
  end

  assign w_any_btn = btn_mode | btn_inc | btn_dec;

  always_comb begin
    w_state_next  = r_state;
    w_scan_next   = 2'd0;
    w_shadow_next = r_shadow;
    w_idle_next   = '0;
    if (r_state == RUN) begin
      w_scan_next = (r_scan == FLD_HR) ? FLD_SEC : r_scan + 2'd1;
      if (btn_mode) begin
        w_state_next = CAP_HR;
      end
    end else if (w_is_cap) begin
      // Out-of-range bus values (e.g. an unset counter) start the edit from zero.
      w_shadow_next = (databus > w_max) ? '0 : databus;
      case (r_state)
        CAP_HR:  w_state_next = EDIT_HR;
        CAP_MIN: w_state_next = EDIT_MIN;
        default: w_state_next = EDIT_SEC;
      endcase
    end else if (w_is_edit) begin
      if (btn_mode) begin
        case (r_state)
          EDIT_HR:  w_state_next = CAP_MIN;
          EDIT_MIN: w_state_next = CAP_SEC;
          default:  w_state_next = RUN;
        endcase
      end else if (btn_inc && !btn_dec) begin
        w_shadow_next = (r_shadow >= w_max) ? '0 : r_shadow + W'(1);
      end else if (btn_dec && !btn_inc) begin
        w_shadow_next = (r_shadow == '0) ? w_max : r_shadow - W'(1);
      end else if (!w_any_btn) begin
        if (r_idle == LP_IDLE_LAST) begin
          w_state_next = RUN;
        end else begin
          w_idle_next = r_idle + IW'(1);
        end
      end
    end else begin
      w_state_next = RUN;
    end
  end

  assign sec_en     = (w_field == FLD_SEC);
  assign min_en     = (w_field == FLD_MIN);
  assign hr_en      = (w_field == FLD_HR);
  assign sec_load   = w_is_edit && (w_field == FLD_SEC);
  assign min_load   = w_is_edit && (w_field == FLD_MIN);
  assign hr_load    = w_is_edit && (w_field == FLD_HR);
  assign load_data  = w_is_edit ? r_shadow : '0;
  assign bus_sel    = w_field;
  assign set_active = (r_state != RUN);
  assign edit_val   = r_shadow;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       clear;
  logic       btn_mode, btn_inc, btn_dec;
  logic [5:0] databus;
  logic       sec_en, min_en, hr_en;
  logic       sec_load, min_load, hr_load;
  logic [5:0] load_data;
  logic [1:0] bus_sel;
  logic       set_active;
  logic [5:0] edit_val;

  typedef struct {
    string       name;
    logic [20:0] exp;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;

  clock_set_ctrl dut (
    .clk(clk), .clear(clear),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .databus(databus),
    .sec_en(sec_en), .min_en(min_en), .hr_en(hr_en),
    .sec_load(sec_load), .min_load(min_load), .hr_load(hr_load),
    .load_data(load_data), .bus_sel(bus_sel),
    .set_active(set_active), .edit_val(edit_val)
  );

  always #5 clk = ~clk;

  // Packed as {hr,min,sec en}{hr,min,sec load} load_data bus_sel set_active edit_val.
  task automatic checkOutput(input item_t it);
    logic [20:0] act;
    act = {hr_en, min_en, sec_en, hr_load, min_load, sec_load,
           load_data, bus_sel, set_active, edit_val};
    total++;
    if (act !== it.exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%b expected=%b", it.name, act, it.exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  task automatic pushExp(input string name, input logic [2:0] en, input logic [2:0] ld,
                         input logic [5:0] ldat, input logic [1:0] bs, input logic sa,
                         input logic [5:0] ev);
    item_t it;
    it.name = name;
    it.exp  = {en, ld, ldat, bs, sa, ev};
    sb.push_back(it);
  endtask

  // Outputs expected during this cycle, and the inputs applied for its closing edge.
  task automatic applyStimulus(input string name, input logic m, input logic i, input logic d,
                               input logic [5:0] bus, input logic [2:0] en,
                               input logic [2:0] ld, input logic [5:0] ldat,
                               input logic [1:0] bs, input logic sa, input logic [5:0] ev);
    btn_mode = m;
    btn_inc  = i;
    btn_dec  = d;
    databus  = bus;
    pushExp(name, en, ld, ldat, bs, sa, ev);
    @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
  endtask

  initial begin
    clear = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; databus = 6'd0;
    @(posedge clk); #1;
    pushExp("reset_hold", 3'b001, 3'b000, 6'd0, 2'd0, 1'b0, 6'd0);
    @(posedge clk); #1;
    clear = 1'b0;

    // RUN scan with btn_inc ignored, then btn_mode
    applyStimulus("run_s0", 0,0,0, 6'd0,  3'b001, 3'b000, 6'd0, 2'd0, 0, 6'd0);
    applyStimulus("run_s1", 0,1,0, 6'd0,  3'b010, 3'b000, 6'd0, 2'd1, 0, 6'd0);
    applyStimulus("run_s2", 0,0,1, 6'd0,  3'b100, 3'b000, 6'd0, 2'd2, 0, 6'd0);
    applyStimulus("run_s3", 0,0,0, 6'd0,  3'b001, 3'b000, 6'd0, 2'd0, 0, 6'd0);
    applyStimulus("run_s4", 0,0,0, 6'd0,  3'b010, 3'b000, 6'd0, 2'd1, 0, 6'd0);
    applyStimulus("run_s5", 1,0,0, 6'd0,  3'b100, 3'b000, 6'd0, 2'd2, 0, 6'd0);
    // hours: capture 22, inc to 23, wrap to 0, dec back to 23
    applyStimulus("cap_hr", 0,1,0, 6'd22, 3'b100, 3'b000, 6'd0, 2'd2, 1, 6'd0);
    applyStimulus("ed_hr22", 0,1,0, 6'd0, 3'b100, 3'b100, 6'd22, 2'd2, 1, 6'd22);
    applyStimulus("ed_hr23", 0,1,0, 6'd0, 3'b100, 3'b100, 6'd23, 2'd2, 1, 6'd23);
    applyStimulus("ed_hr0",  0,0,1, 6'd0, 3'b100, 3'b100, 6'd0,  2'd2, 1, 6'd0);
    applyStimulus("ed_hr23b",1,0,0, 6'd0, 3'b100, 3'b100, 6'd23, 2'd2, 1, 6'd23);
    // minutes: capture 0, dec wraps to 59, inc+dec holds, mode+inc leaves
    applyStimulus("cap_min", 0,0,0, 6'd0, 3'b010, 3'b000, 6'd0,  2'd1, 1, 6'd23);
    applyStimulus("ed_min0", 0,0,1, 6'd0, 3'b010, 3'b010, 6'd0,  2'd1, 1, 6'd0);
    applyStimulus("ed_min59",0,1,1, 6'd0, 3'b010, 3'b010, 6'd59, 2'd1, 1, 6'd59);
    applyStimulus("ed_minhold",1,1,0,6'd0,3'b010, 3'b010, 6'd59, 2'd1, 1, 6'd59);
    // seconds: bus 63 clamps to 0, dec wraps to 59, inc wraps to 0, mode to RUN
    applyStimulus("cap_sec", 0,0,0, 6'd63, 3'b001, 3'b000, 6'd0, 2'd0, 1, 6'd59);
    applyStimulus("ed_sec0", 0,0,1, 6'd0, 3'b001, 3'b001, 6'd0,  2'd0, 1, 6'd0);
    applyStimulus("ed_sec59",0,1,0, 6'd0, 3'b001, 3'b001, 6'd59, 2'd0, 1, 6'd59);
    applyStimulus("ed_sec0b",1,0,0, 6'd0, 3'b001, 3'b001, 6'd0,  2'd0, 1, 6'd0);
    applyStimulus("back_run0",0,0,0,6'd0, 3'b001, 3'b000, 6'd0,  2'd0, 0, 6'd0);
    applyStimulus("back_run1",1,0,0,6'd5, 3'b010, 3'b000, 6'd0,  2'd1, 0, 6'd0);
    // hours quick pass, then minutes left idle until timeout
    applyStimulus("cap_hr2", 0,0,0, 6'd5, 3'b100, 3'b000, 6'd0,  2'd2, 1, 6'd0);
    applyStimulus("ed_hr5",  1,0,0, 6'd0, 3'b100, 3'b100, 6'd5,  2'd2, 1, 6'd5);
    applyStimulus("cap_min2",0,0,0, 6'd30,3'b010, 3'b000, 6'd0,  2'd1, 1, 6'd5);
    for (int k = 0; k < 10; k++) begin
      applyStimulus($sformatf("idle_min%0d", k), 0,0,0, 6'd0,
                    3'b010, 3'b010, 6'd30, 2'd1, 1, 6'd30);
    end
    applyStimulus("tmo_run0", 0,0,0, 6'd0, 3'b001, 3'b000, 6'd0, 2'd0, 0, 6'd30);
    applyStimulus("tmo_run1", 1,0,0, 6'd0, 3'b010, 3'b000, 6'd0, 2'd1, 0, 6'd30);
    applyStimulus("cap_hr3",  0,0,0, 6'd12,3'b100, 3'b000, 6'd0, 2'd2, 1, 6'd30);
    applyStimulus("ed_hr12",  0,0,0, 6'd0, 3'b100, 3'b100, 6'd12,2'd2, 1, 6'd12);
    // asynchronous clear between edges while in EDIT_HR
    #1;
    clear = 1'b1;
    pushExp("clear_async", 3'b001, 3'b000, 6'd0, 2'd0, 1'b0, 6'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    applyStimulus("post_clr0", 0,0,0, 6'd0, 3'b001, 3'b000, 6'd0, 2'd0, 0, 6'd0);
    applyStimulus("post_clr1", 0,0,0, 6'd0, 3'b010, 3'b000, 6'd0, 2'd1, 0, 6'd0);
    applyStimulus("post_clr2", 0,0,0, 6'd0, 3'b100, 3'b000, 6'd0, 2'd2, 0, 6'd0);

    for (int w = 0; w < 5 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: pending=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Mode/set controller for the 6-bit time counters (seconds, minutes, hours) that share one 6-bit databus.
- In RUN it time-multiplexes the databus among the three counters for the display scanner.
- In SET it captures one field from the bus, edits a shadow copy with inc/dec buttons, and holds the counter at that value through its load port.
- Sits between the debounced button front-end and the counter bank.

Parameters:
- W, 6, counter/databus width
- SEC_MAX, 59, seconds wrap value
- MIN_MAX, 59, minutes wrap value
- HR_MAX, 23, hours wrap value
- TIMEOUT, 10, idle clk cycles in an edit state before auto-return to RUN (≥2)

Ports:
- clk  in  1  system clock; counters share it
- clear  in  1  asynchronous active-high reset
- btn_mode  in  1  single-cycle pulse, debounced upstream; advance mode
- btn_inc  in  1  single-cycle pulse; increment field being edited
- btn_dec  in  1  single-cycle pulse; decrement field being edited
- databus  in  W  shared bus, driven by whichever counter's enable is high
- sec_en, min_en, hr_en  out  1 each  bus enables to counters; at most one high
- sec_load, min_load, hr_load  out  1 each  counter load strobes; at most one high
- load_data  out  W  value applied to asserted load
- bus_sel  out  2  0=sec, 1=min, 2=hr, 3=none; tags current bus owner for display
- set_active  out  1  high in any non-RUN state
- edit_val  out  W  shadow register, for blinking set display

Behaviour:
- States: RUN, CAP_HR, EDIT_HR, CAP_MIN, EDIT_MIN, CAP_SEC, EDIT_SEC. State register, scan pointer, shadow and idle counter are flops. All outputs decode combinationally from them.
- clear asserted (any time, mid-edit included): state=RUN, scan=0, shadow=0, idle=0. Outputs are then sec_en=1, other enables 0, all loads 0, load_data=0, bus_sel=0, set_active=0, edit_val=0. No load pulse is issued on reset exit.
- RUN:
  - Scan pointer cycles sec→min→hr→sec, one step per clk. The matching *_en=1 and bus_sel equals the pointer.
  - Loads 0. btn_inc/btn_dec ignored.
  - btn_mode → CAP_HR next edge.
- CAP_x (one cycle):
  - Field's en=1, bus_sel=field, no load.
  - At the edge, shadow ← databus, clamped to 0 if > field MAX. Then → EDIT_x; idle=0.
  - Buttons in CAP are ignored, including btn_mode.
  - The counter's own increment at that edge is overwritten by the first EDIT load. Losing one tick is accepted.
- EDIT_x:
  - Field's load=1 every cycle with load_data=shadow, so the counter holds the shadow value. Field's en=1, bus_sel=field. Other fields keep counting with en=0.
  - btn_inc alone: shadow+1, MAX wraps to 0.
  - btn_dec alone: shadow−1, 0 wraps to MAX.
  - btn_inc and btn_dec together: no change, but idle is still reset.
  - btn_mode: EDIT_HR→CAP_MIN, EDIT_MIN→CAP_SEC, EDIT_SEC→RUN with scan=0. If btn_mode arrives with inc/dec in the same cycle, mode wins and shadow is unchanged.
  - Any button pulse sets idle=0; otherwise idle+1.
  - When idle reaches TIMEOUT−1 with no button, → RUN with scan=0. The counter keeps the last loaded value.
- Arithmetic: shadow is W bits, and wrap compares are against the parameter MAX, never 2^W.
- Invariant: at most one en and at most one load high in any cycle. In EDIT states, en and load of the same field are both high.

Test Plan:
- Reset then 6 idle clocks → bus_sel sequence 0,0(reset),1,2,0,1,2 with one-hot en; all loads 0.
- In RUN, btn_mode; CAP_HR sees databus=22 → EDIT_HR: hr_load=1, load_data=22. Then btn_inc ×2 → load_data 23 then 0 (wrap at HR_MAX).
- EDIT_MIN, shadow=0; btn_dec → 59. btn_inc+btn_dec in the same cycle → stays 59. btn_mode+btn_inc in the same cycle → CAP_SEC, and min_load drops with last load_data=59.
- Full pass: three btn_mode pulses from CAP→EDIT_SEC with databus=63 at CAP_SEC → shadow clamped to 0. A further btn_mode → RUN, set_active=0, bus_sel=0 next cycle.
- EDIT_MIN with no buttons, TIMEOUT=10 → exactly 10 cycles of min_load=1, then RUN.
- Assert clear mid-EDIT_HR (asynchronous, between edges) → outputs go to reset values immediately; hr_load=0 with no further load after release.
